// File: rtl/register_file_if.sv
// Issue/commit/read-port bundle between the pipeline and the architectural register file.
// The master side is the pipeline. The slave side is the register file.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
);
    logic              rdy;
    logic              in_flush;
    logic              in_rename;
    logic [4:0]        in_rename_reg;
    logic [ROB_W-1:0]  in_rename_robnum;
    logic              in_commit;
    logic [4:0]        in_commit_reg;
    logic [DATA_W-1:0] in_commit_data;
    logic [ROB_W-1:0]  in_commit_robnum;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [ROB_W-1:0]  rs1_robnum;
    logic [ROB_W-1:0]  rs2_robnum;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    modport master (
        output rdy, in_flush, in_rename, in_rename_reg, in_rename_robnum,
               in_commit, in_commit_reg, in_commit_data, in_commit_robnum,
               rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy, rs1_robnum, rs2_robnum, rs1_data, rs2_data
    );

    modport slave (
        input  rdy, in_flush, in_rename, in_rename_reg, in_rename_robnum,
               in_commit, in_commit_reg, in_commit_data, in_commit_robnum,
               rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy, rs1_robnum, rs2_robnum, rs1_data, rs2_data
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags and a commit bypass on both read ports.
// Register 0 is hard-wired to zero. A rename wins over a commit to the same register on the same edge.
module register_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    register_file_if.slave    bus
);
    logic [DATA_W-1:0]  data_q [REG_NUM];
    logic [DATA_W-1:0]  data_d [REG_NUM];
    logic [ROB_W-1:0]   tag_q  [REG_NUM];
    logic [ROB_W-1:0]   tag_d  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (bus.rdy) begin
            if (bus.in_commit && bus.in_commit_reg != 5'd0) begin
                data_d[bus.in_commit_reg] = bus.in_commit_data;
                if (busy_q[bus.in_commit_reg] && tag_q[bus.in_commit_reg] == bus.in_commit_robnum)
                    busy_d[bus.in_commit_reg] = 1'b0;
            end
            // Flush drops any same-edge rename; the commit value above is still kept.
            if (bus.in_flush) begin
                busy_d = '0;
                for (int i = 0; i < REG_NUM; i++)
                    tag_d[i] = '0;
            end else if (bus.in_rename && bus.in_rename_reg != 5'd0) begin
                busy_d[bus.in_rename_reg] = 1'b1;
                tag_d[bus.in_rename_reg]  = bus.in_rename_robnum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = bus.in_commit && bus.in_commit_reg == bus.rs1_addr;
    assign rs2_hit = bus.in_commit && bus.in_commit_reg == bus.rs2_addr;

    always_comb begin
        bus.rs1_busy   = 1'b0;
        bus.rs1_robnum = '0;
        bus.rs1_data   = '0;
        if (bus.rs1_addr != 5'd0) begin
            bus.rs1_busy   = busy_q[bus.rs1_addr] &&
                             !(rs1_hit && tag_q[bus.rs1_addr] == bus.in_commit_robnum);
            bus.rs1_robnum = bus.rs1_busy ? tag_q[bus.rs1_addr] : '0;
            bus.rs1_data   = rs1_hit ? bus.in_commit_data : data_q[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_busy   = 1'b0;
        bus.rs2_robnum = '0;
        bus.rs2_data   = '0;
        if (bus.rs2_addr != 5'd0) begin
            bus.rs2_busy   = busy_q[bus.rs2_addr] &&
                             !(rs2_hit && tag_q[bus.rs2_addr] == bus.in_commit_robnum);
            bus.rs2_robnum = bus.rs2_busy ? tag_q[bus.rs2_addr] : '0;
            bus.rs2_data   = rs2_hit ? bus.in_commit_data : data_q[bus.rs2_addr];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus a randomized run against a rule-level model.
module tb_register_file;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    register_file_if #(.DATA_W(32), .ROB_W(4)) bus ();

    register_file #(.REG_NUM(32), .DATA_W(32), .ROB_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    // Apply the architectural rules for one rising edge using the held strobes.
    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (bus.rdy) begin
            if (bus.in_commit && bus.in_commit_reg != 0) begin
                m_data[bus.in_commit_reg] = bus.in_commit_data;
                if (m_busy[bus.in_commit_reg] && m_tag[bus.in_commit_reg] == bus.in_commit_robnum)
                    m_busy[bus.in_commit_reg] = 1'b0;
            end
            if (bus.in_flush) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = '0;
                end
            end else if (bus.in_rename && bus.in_rename_reg != 0) begin
                m_busy[bus.in_rename_reg] = 1'b1;
                m_tag[bus.in_rename_reg]  = bus.in_rename_robnum;
            end
        end
    endfunction

    function automatic void exp_read(input logic [4:0] a, output bit b,
                                     output logic [3:0] r, output logic [31:0] d);
        bit hit;
        hit = bus.in_commit && bus.in_commit_reg == a;
        if (a == 0) begin
            b = 1'b0; r = '0; d = '0;
        end else begin
            b = m_busy[a] && !(hit && m_tag[a] == bus.in_commit_robnum);
            r = b ? m_tag[a] : 4'd0;
            d = hit ? bus.in_commit_data : m_data[a];
        end
    endfunction

    task automatic clear_strobes();
        bus.in_flush         = 1'b0;
        bus.in_rename        = 1'b0;
        bus.in_rename_reg    = '0;
        bus.in_rename_robnum = '0;
        bus.in_commit        = 1'b0;
        bus.in_commit_reg    = '0;
        bus.in_commit_data   = '0;
        bus.in_commit_robnum = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        clear_strobes();
        #1;
    endtask

    task automatic rename(input int r, input int t);
        bus.in_rename = 1'b1; bus.in_rename_reg = 5'(r); bus.in_rename_robnum = 4'(t);
    endtask

    task automatic commit(input int r, input int t, input logic [31:0] d);
        bus.in_commit = 1'b1; bus.in_commit_reg = 5'(r);
        bus.in_commit_robnum = 4'(t); bus.in_commit_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        rename(4, 2);
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(31 - a);
            #1;
            total++;
            if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'd0 ||
                bus.rs2_busy !== 1'b0 || bus.rs2_robnum !== 4'd0 || bus.rs2_data !== 32'd0) begin
                bad++;
                $display("FAIL reset_x%0d: got rs1 %0b/%0d/%h rs2 %0b/%0d/%h, want all zero",
                         a, bus.rs1_busy, bus.rs1_robnum, bus.rs1_data,
                         bus.rs2_busy, bus.rs2_robnum, bus.rs2_data);
            end
        end
    endtask

    task automatic test_bypass();
        rename(5, 3);
        step();
        bus.rs1_addr = 5'd5;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_robnum !== 4'd3) begin
            bad++;
            $display("FAIL bypass_pending: got busy=%0b rob=%0d, want 1/3", bus.rs1_busy, bus.rs1_robnum);
        end
        commit(5, 3, 32'h1234);
        #1;
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'h1234) begin
            bad++;
            $display("FAIL bypass_same_cycle: got %0b/%0d/%h, want 0/0/1234",
                     bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
        step();
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'h1234) begin
            bad++;
            $display("FAIL bypass_stored: got %0b/%0d/%h, want 0/0/1234",
                     bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
    endtask

    task automatic test_stale_commit();
        rename(5, 3); step();
        rename(5, 7); step();
        commit(5, 3, 32'hAA); step();
        bus.rs1_addr = 5'd5;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_robnum !== 4'd7 || bus.rs1_data !== 32'hAA) begin
            bad++;
            $display("FAIL stale_commit: got %0b/%0d/%h, want 1/7/aa",
                     bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
    endtask

    task automatic test_same_edge();
        rename(6, 2); step();
        commit(6, 2, 32'h55);
        rename(6, 9);
        step();
        bus.rs2_addr = 5'd6;
        #1;
        total++;
        if (bus.rs2_busy !== 1'b1 || bus.rs2_robnum !== 4'd9 || bus.rs2_data !== 32'h55) begin
            bad++;
            $display("FAIL same_edge: got %0b/%0d/%h, want 1/9/55",
                     bus.rs2_busy, bus.rs2_robnum, bus.rs2_data);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            rename(r, r);
            step();
        end
        bus.in_flush = 1'b1;
        commit(1, 1, 32'h77);
        rename(8, 4);
        step();
        for (int r = 1; r <= 4; r++) begin
            bus.rs1_addr = 5'(r);
            #1;
            total++;
            if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0) begin
                bad++;
                $display("FAIL flush_x%0d: got busy=%0b rob=%0d, want 0/0", r, bus.rs1_busy, bus.rs1_robnum);
            end
        end
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd8;
        #1;
        total++;
        if (bus.rs1_data !== 32'h77 || bus.rs2_busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_commit: got x1=%h x8busy=%0b, want 77/0", bus.rs1_data, bus.rs2_busy);
        end
    endtask

    task automatic test_x0_rdy();
        rename(0, 5);
        commit(0, 5, 32'hFFFF);
        bus.rs1_addr = 5'd0;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'd0) begin
            bad++;
            $display("FAIL x0_bypass: got %0b/%0d/%h, want 0/0/0", bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
        step();
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'd0) begin
            bad++;
            $display("FAIL x0_stored: got %0b/%0d/%h, want 0/0/0", bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
        bus.rdy = 1'b0;
        rename(9, 6);
        step();
        bus.rdy = 1'b0;
        bus.in_flush = 1'b1;
        commit(9, 6, 32'h1234);
        step();
        bus.rdy = 1'b1;
        bus.rs1_addr = 5'd9;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_robnum !== 4'd0 || bus.rs1_data !== 32'd0) begin
            bad++;
            $display("FAIL rdy_low: got %0b/%0d/%h, want 0/0/0", bus.rs1_busy, bus.rs1_robnum, bus.rs1_data);
        end
        bus.rs1_addr = 5'd8;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b0) begin
            bad++;
            $display("FAIL rdy_low_flush: got busy=%0b, want 0", bus.rs1_busy);
        end
    endtask

    task automatic test_reset_mid();
        rename(3, 5); step();
        rst_n = 1'b0;
        commit(3, 5, 32'h99);
        rename(7, 1);
        step();
        rst_n = 1'b1;
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd7;
        #1;
        total++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'd0 || bus.rs1_robnum !== 4'd0 ||
            bus.rs2_busy !== 1'b0 || bus.rs2_robnum !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got x3 %0b/%0d/%h x7 busy=%0b, want zero",
                     bus.rs1_busy, bus.rs1_robnum, bus.rs1_data, bus.rs2_busy);
        end
        rename(3, 1);
        step();
        total++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_robnum !== 4'd1) begin
            bad++;
            $display("FAIL reset_release: got busy=%0b rob=%0d, want 1/1", bus.rs1_busy, bus.rs1_robnum);
        end
    endtask

    task automatic test_random();
        bit          eb;
        logic [3:0]  er;
        logic [31:0] ed;
        int          cr;
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(63) != 0);
            bus.rdy = ($urandom_range(7) != 0);
            bus.in_flush = ($urandom_range(15) == 0);
            if ($urandom_range(1) == 1) rename($urandom_range(31), $urandom_range(15));
            if ($urandom_range(1) == 1) begin
                cr = $urandom_range(31);
                commit(cr, ($urandom_range(2) != 0) ? int'(m_tag[cr]) : $urandom_range(15), $urandom);
            end
            bus.rs1_addr = ($urandom_range(3) == 0) ? bus.in_commit_reg : 5'($urandom_range(31));
            bus.rs2_addr = 5'($urandom_range(31));
            #1;
            exp_read(bus.rs1_addr, eb, er, ed);
            total++;
            if (bus.rs1_busy !== eb || bus.rs1_robnum !== er || bus.rs1_data !== ed) begin
                bad++;
                $display("FAIL random_rs1 n=%0d x%0d: got %0b/%0d/%h, want %0b/%0d/%h",
                         n, bus.rs1_addr, bus.rs1_busy, bus.rs1_robnum, bus.rs1_data, eb, er, ed);
            end
            exp_read(bus.rs2_addr, eb, er, ed);
            total++;
            if (bus.rs2_busy !== eb || bus.rs2_robnum !== er || bus.rs2_data !== ed) begin
                bad++;
                $display("FAIL random_rs2 n=%0d x%0d: got %0b/%0d/%h, want %0b/%0d/%h",
                         n, bus.rs2_addr, bus.rs2_busy, bus.rs2_robnum, bus.rs2_data, eb, er, ed);
            end
            step();
        end
        rst_n   = 1'b1;
        bus.rdy = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        clear_strobes();
        model_reset();
        test_reset();
        test_bypass();
        test_stale_commit();
        test_same_edge();
        test_flush();
        test_x0_rdy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
